oam_dma_engine: RTL and testbench

- NES sprite DMA ($4014) master; sits directly upstream of the CPU work-RAM single-port no-change RAM and drives its address/read port.
- On a CPU write to $4014 it halts the CPU, reads 256 bytes from page {dma_page, 8'h00..8'hFF}, and writes each byte to PPU OAM via the $2004 path.
- Reproduces the 2A03 timing of 513/514 halted CPU cycles.

---
 rtl/nes_dma_pkg.sv | 22 ++
 rtl/oam_dma_engine.sv | 127 ++++++++++++
 tb/tb_oam_dma_engine.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/nes_dma_pkg.sv
// Shared types and constants for the NES sprite (OAM) DMA engine.
// Consumed by oam_dma_engine; the ALIGN state is only used when OAM_DMA_ALIGN_EN is defined.
package nes_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_e;

    localparam logic [15:0] OAM_DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_REG_ADDR = 16'h2004;
    localparam int          XFER_LEN_DEFAULT  = 256;

    // Parity 0 is a get (read) cycle, 1 is a put (write) cycle.
    function automatic logic is_get(input logic parity);
        return !parity;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// NES $4014 sprite DMA master: halts the CPU and copies one page from work RAM to OAM.
// Build option OAM_DMA_ALIGN_EN adds an explicit ALIGN state; otherwise READ waits for a get cycle.
module oam_dma_engine
    import nes_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int XFER_LEN   = XFER_LEN_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_ce_i,
    input  logic                  dma_wr_i,
    input  logic [7:0]            dma_page_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  oam_wr_o,
    output logic [DATA_WIDTH-1:0] oam_data_o,
    output logic                  cpu_rdy_o,
    output logic                  busy_o
);

    localparam int               IDX_W    = ADDR_WIDTH - 8;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

    dma_state_e            state_q, state_d;
    logic                  parity_q, parity_d;
    logic [7:0]            page_q, page_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  cpu_rdy_q, cpu_rdy_d;
    logic                  mem_rd;
    logic                  oam_wr;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        parity_d = parity_q ^ cpu_ce_i;
        mem_rd   = 1'b0;
        oam_wr   = 1'b0;

        if (cpu_ce_i) begin
            unique case (state_q)
                IDLE: begin
                    if (dma_wr_i) begin
                        page_d  = dma_page_i;
                        idx_d   = '0;
                        state_d = HALT;
                    end
                end
                HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                    // A get now means the following strobe is a put: burn it in ALIGN.
                    state_d = is_get(parity_q) ? ALIGN : READ;
`else
                    state_d = READ;
`endif
                end
`ifdef OAM_DMA_ALIGN_EN
                ALIGN: begin
                    state_d = READ;
                end
`endif
                READ: begin
                    // Without ALIGN a put-parity start idles here for one strobe, issuing no read.
                    if (is_get(parity_q)) begin
                        mem_rd  = 1'b1;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (!is_get(parity_q)) begin
                        oam_wr = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = IDLE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = READ;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // RAM douta is valid the clock after the read strobe.
        rd_pend_d = mem_rd;
        data_d    = rd_pend_q ? rdata_i : data_q;
        cpu_rdy_d = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            parity_q  <= 1'b0;
            page_q    <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            rd_pend_q <= 1'b0;
            cpu_rdy_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            parity_q  <= parity_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            rd_pend_q <= rd_pend_d;
            cpu_rdy_q <= cpu_rdy_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign mem_addr_o = busy_o ? {page_q, idx_q} : '0;
    assign mem_rd_o   = mem_rd;
    assign oam_wr_o   = oam_wr;
    assign oam_data_o = data_q;
    assign cpu_rdy_o  = cpu_rdy_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed testbench for oam_dma_engine: halt counts, address/data order, retrigger, reset, spacing.
module tb_oam_dma_engine;

    localparam int XFER = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_ce = 1'b0;
    logic        dma_wr = 1'b0;
    logic [7:0]  dma_page = 8'h00;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  rdata = 8'h00;
    logic        oam_wr;
    logic [7:0]  oam_data;
    logic        cpu_rdy;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    int spacing = 2;

    logic        s_rdy, s_rd, s_wr, s_busy, s_par;
    logic [15:0] s_addr;
    logic [7:0]  s_data;

    oam_dma_engine dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cpu_ce_i   (cpu_ce),
        .dma_wr_i   (dma_wr),
        .dma_page_i (dma_page),
        .mem_addr_o (mem_addr),
        .mem_rd_o   (mem_rd),
        .rdata_i    (rdata),
        .oam_wr_o   (oam_wr),
        .oam_data_o (oam_data),
        .cpu_rdy_o  (cpu_rdy),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        return 8'(a[7:0] * 8'd3 + a[15:8] * 8'd29 + 8'h11);
    endfunction

    // Single-port no-change work RAM: douta updates only on a read.
    always @(posedge clk) begin
        if (mem_rd) rdata <= ram_byte(mem_addr);
    end

    task automatic strobe(input logic wr, input logic [7:0] pg);
        @(negedge clk);
        cpu_ce = 1'b1;
        dma_wr = wr;
        dma_page = pg;
        #1;
        s_rdy  = cpu_rdy;
        s_rd   = mem_rd;
        s_wr   = oam_wr;
        s_busy = busy;
        s_addr = mem_addr;
        s_data = oam_data;
        s_par  = strobe_cnt[0];
        @(negedge clk);
        cpu_ce = 1'b0;
        dma_wr = 1'b0;
        for (int k = 2; k < spacing; k++) @(negedge clk);
        strobe_cnt++;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got=%b want=1", cpu_rdy); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (mem_rd !== 1'b0 || oam_wr !== 1'b0) begin n_fail++; $display("FAIL reset_strobes rd=%b wr=%b want=0,0", mem_rd, oam_wr); end
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got=%h want=0000", mem_addr); end
        n_checks++; if (oam_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h want=00", oam_data); end
        @(negedge clk);
        rst = 1'b0;
        strobe_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            strobe(1'b0, 8'h00);
            n_checks++;
            if (s_rd !== 1'b0 || s_wr !== 1'b0 || s_busy !== 1'b0 || s_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_strobe%0d rd=%b wr=%b busy=%b rdy=%b want=0,0,0,1", i, s_rd, s_wr, s_busy, s_rdy);
            end
        end
    endtask

    task automatic test_wr_no_ce();
        @(negedge clk);
        dma_wr = 1'b1;
        dma_page = 8'h09;
        for (int i = 0; i < 5; i++) @(negedge clk);
        dma_wr = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_no_ce_busy got=%b want=0", busy); end
        n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_no_ce_rdy got=%b want=1", cpu_rdy); end
    endtask

    task automatic test_transfer(input string name, input logic [7:0] page, input bit odd,
                                 input int retrig_at, input logic [7:0] retrig_page);
        int halted, reads, writes;
        bit done;
        logic [15:0] exp_addr, last_addr;
        logic [7:0]  exp_data;
        halted = 0; reads = 0; writes = 0; done = 0; last_addr = 16'h0000;
        while (strobe_cnt % 2 != int'(odd)) strobe(1'b0, 8'h00);
        strobe(1'b1, page);
        n_checks++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL %s trigger_rdy got=%b want=1", name, s_rdy); end
        for (int i = 0; i < 700 && !done; i++) begin
            strobe(i + 1 == retrig_at, retrig_page);
            if (s_rdy === 1'b1) begin
                done = 1;
            end else begin
                halted++;
                if (s_rd === 1'b1) begin
                    exp_addr = {page, reads[7:0]};
                    n_checks++;
                    if (s_addr !== exp_addr) begin n_fail++; $display("FAIL %s rd_addr%0d got=%h want=%h", name, reads, s_addr, exp_addr); end
                    if (reads == 0) begin
                        n_checks++;
                        if (s_par !== 1'b0) begin n_fail++; $display("FAIL %s first_rd_parity got=%b want=0", name, s_par); end
                    end
                    last_addr = s_addr;
                    reads++;
                end
                if (s_wr === 1'b1) begin
                    exp_data = ram_byte({page, writes[7:0]});
                    n_checks++;
                    if (s_data !== exp_data) begin n_fail++; $display("FAIL %s oam_data%0d got=%h want=%h", name, writes, s_data, exp_data); end
                    writes++;
                end
            end
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL %s timeout halted=%0d want_done=1", name, halted); end
        n_checks++; if (halted != 1 + int'(odd) + 2 * XFER) begin n_fail++; $display("FAIL %s halted got=%0d want=%0d", name, halted, 1 + int'(odd) + 2 * XFER); end
        n_checks++; if (reads != XFER) begin n_fail++; $display("FAIL %s reads got=%0d want=%0d", name, reads, XFER); end
        n_checks++; if (writes != XFER) begin n_fail++; $display("FAIL %s writes got=%0d want=%0d", name, writes, XFER); end
        n_checks++; if (last_addr !== {page, 8'hFF}) begin n_fail++; $display("FAIL %s last_addr got=%h want=%h", name, last_addr, {page, 8'hFF}); end
        n_checks++; if (s_busy !== 1'b0 || s_addr !== 16'h0000) begin n_fail++; $display("FAIL %s idle_after busy=%b addr=%h want=0,0000", name, s_busy, s_addr); end
    endtask

    task automatic test_mid_reset();
        int writes;
        int bad;
        writes = 0; bad = 0;
        strobe(1'b1, 8'h04);
        for (int i = 0; i < 700 && writes < 40; i++) begin
            strobe(1'b0, 8'h00);
            if (s_wr === 1'b1) writes++;
        end
        n_checks++; if (writes != 40) begin n_fail++; $display("FAIL mid_reset writes_before got=%0d want=40", writes); end
        @(negedge clk);
        cpu_ce = 1'b1;
        rst = 1'b1;
        #1;
        n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_reset_rdy got=%b want=1", cpu_rdy); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
        n_checks++; if (oam_wr !== 1'b0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL mid_reset_strobes wr=%b rd=%b want=0,0", oam_wr, mem_rd); end
        @(negedge clk);
        cpu_ce = 1'b0;
        rst = 1'b0;
        strobe_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            strobe(1'b0, 8'h00);
            if (s_rd !== 1'b0 || s_wr !== 1'b0 || s_rdy !== 1'b1) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_reset_quiet bad_strobes got=%0d want=0", bad); end
    endtask

    initial begin
        test_reset();
        test_wr_no_ce();
        test_transfer("even_p02", 8'h02, 1'b0, -1, 8'h00);
        test_transfer("odd_p07", 8'h07, 1'b1, -1, 8'h00);
        test_transfer("retrig_p03", 8'h03, 1'b0, 100, 8'h05);
        test_mid_reset();
        test_transfer("after_reset_p01", 8'h01, 1'b1, -1, 8'h00);
        spacing = 3;
        test_transfer("sp3_even_p10", 8'h10, 1'b0, -1, 8'h00);
        test_transfer("sp3_odd_p11", 8'h11, 1'b1, -1, 8'h00);
        spacing = 12;
        test_transfer("sp12_even_p12", 8'h12, 1'b0, -1, 8'h00);
        test_transfer("sp12_odd_p13", 8'h13, 1'b1, -1, 8'h00);
        spacing = 2;
        test_transfer("page_ff", 8'hFF, 1'b0, -1, 8'h00);
        test_transfer("after_ff_p20", 8'h20, 1'b1, -1, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
